// File: rtl/shift_reg_univ.sv
// shift_reg_univ: parameterised universal shift register.
// Modes: hold, shift right/left, parallel load, clear, optional rotate.
// A shift counter wraps every WIDTH shift steps and pulses frame_done on the wrap.
// Optional feature macro: SHIFT_REG_UNIV_ROTATE_EN. When it is defined, modes 100/101
// rotate. When it is undefined, those modes behave as hold and no rotate logic is built.

// Per-bit next-state selector. Priority order: clear, load, right, left, hold.
module shift_reg_univ_cell (
  input  logic sel_r,
  input  logic sel_l,
  input  logic sel_ld,
  input  logic sel_clr,
  input  logic q,
  input  logic hi,
  input  logic lo,
  input  logic p,
  output logic d
);
  // pick this bit's next value from the decoded operation
  always_comb begin
    d = q;
    if (sel_clr)     d = 1'b0;
    else if (sel_ld) d = p;
    else if (sel_r)  d = hi;
    else if (sel_l)  d = lo;
  end
endmodule

module shift_reg_univ #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             s_in_msb,
  input  logic             s_in_lsb,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] Q,
  output logic             s_out_lsb,
  output logic             s_out_msb,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic             sel_r, sel_l, sel_ld, sel_clr, step;
  logic             msb_fill, lsb_fill;
  logic [WIDTH-1:0] hi_src, lo_src, q_next;

  // decode mode into one-hot selects and the serial fill bits
  always_comb begin
    sel_ld   = (mode == 3'b011);
    sel_clr  = (mode == 3'b110);
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    sel_r    = (mode == 3'b001) || (mode == 3'b100);
    sel_l    = (mode == 3'b010) || (mode == 3'b101);
    msb_fill = (mode == 3'b100) ? Q[0] : s_in_msb;
    lsb_fill = (mode == 3'b101) ? Q[WIDTH-1] : s_in_lsb;
`else
    sel_r    = (mode == 3'b001);
    sel_l    = (mode == 3'b010);
    msb_fill = s_in_msb;
    lsb_fill = s_in_lsb;
`endif
    step     = sel_r || sel_l;
  end

  // each bit sees its upper and lower neighbour; the ends take the fill bits
  assign hi_src = {msb_fill, Q[WIDTH-1:1]};
  assign lo_src = {Q[WIDTH-2:0], lsb_fill};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    shift_reg_univ_cell u_cell (
      .sel_r   (sel_r),
      .sel_l   (sel_l),
      .sel_ld  (sel_ld),
      .sel_clr (sel_clr),
      .q       (Q[i]),
      .hi      (hi_src[i]),
      .lo      (lo_src[i]),
      .p       (p_in[i]),
      .d       (q_next[i])
    );
  end

  // register, shift counter and wrap pulse; frame_done is 0 unless this edge wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q          <= RESET_VAL;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (en) begin
        Q <= q_next;
        if (sel_ld || sel_clr) begin
          cnt <= '0;
        end else if (step) begin
          if (cnt == CNT_MAX) begin
            cnt        <= '0;
            frame_done <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  end

  // serial taps, visible before the edge that shifts them out
  assign s_out_lsb = Q[0];
  assign s_out_msb = Q[WIDTH-1];
endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed self-checking bench for shift_reg_univ (WIDTH=8, RESET_VAL=A5).
module tb_shift_reg_univ;
  logic       clk = 1'b0;
  logic       rst, en, s_in_msb, s_in_lsb;
  logic [2:0] mode;
  logic [7:0] p_in, Q;
  logic       s_out_lsb, s_out_msb, frame_done;
  logic [2:0] cnt;
  int         errors = 0;
  int         checks = 0;

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s_in_msb(s_in_msb),
    .s_in_lsb(s_in_lsb), .p_in(p_in), .Q(Q), .s_out_lsb(s_out_lsb),
    .s_out_msb(s_out_msb), .cnt(cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] q, input logic [2:0] c, input logic fd);
    chk({tag, ".Q"}, 32'(Q), 32'(q));
    chk({tag, ".cnt"}, 32'(cnt), 32'(c));
    chk({tag, ".fd"}, 32'(frame_done), 32'(fd));
  endtask

  logic [7:0] ser_lsb = 8'b0011_1100;
  logic [7:0] ser_q [8] = '{8'h9E, 8'hCF, 8'hE7, 8'hF3, 8'hF9, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] rot_q [8] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'b000; s_in_msb = 1'b0; s_in_lsb = 1'b0; p_in = 8'h00;
    #3;
    chk_state("reset_async", 8'hA5, 3'd0, 1'b0);
    step();
    chk_state("reset_held", 8'hA5, 3'd0, 1'b0);
    rst = 1'b0;

    // parallel load
    en = 1'b1; mode = 3'b011; p_in = 8'h3C;
    step();
    chk_state("load_3c", 8'h3C, 3'd0, 1'b0);
    chk("load_msb_tap", 32'(s_out_msb), 32'(0));

    // serialize: shift right with msb fill 1
    mode = 3'b001; s_in_msb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ser_lsb_tap%0d", k), 32'(s_out_lsb), 32'(ser_lsb[k]));
      step();
      chk_state($sformatf("ser%0d", k), ser_q[k], 3'((k + 1) % 8), (k == 7));
    end
    chk("ser_msb_tap", 32'(s_out_msb), 32'(1));
    en = 1'b0;
    step();
    chk_state("en_off_after_wrap", 8'hFF, 3'd0, 1'b0);
    en = 1'b1; mode = 3'b000;
    step();
    chk_state("hold", 8'hFF, 3'd0, 1'b0);

    // shift left with enable gaps
    mode = 3'b011; p_in = 8'h01;
    step();
    mode = 3'b010; s_in_lsb = 1'b0;
    for (int j = 0; j < 6; j++) begin
      en = (j % 2 == 0);
      step();
      chk_state($sformatf("shl_gap%0d", j), 8'h01 << (j / 2 + 1), 3'(j / 2 + 1), 1'b0);
    end
    en = 1'b1; s_in_lsb = 1'b1;
    step();
    chk_state("shl_fill1", 8'h11, 3'd4, 1'b0);

    // load preempts wrap
    mode = 3'b011; p_in = 8'h00;
    step();
    mode = 3'b001; s_in_msb = 1'b0;
    repeat (7) step();
    chk("pre_load_cnt", 32'(cnt), 32'(7));
    mode = 3'b011; p_in = 8'h5A;
    step();
    chk_state("load_preempt", 8'h5A, 3'd0, 1'b0);

    // clear preempts wrap
    mode = 3'b001;
    repeat (7) step();
    chk_state("pre_clr", 8'h00, 3'd7, 1'b0);
    mode = 3'b011; p_in = 8'hC3;
    step();
    mode = 3'b010; s_in_lsb = 1'b0;
    repeat (7) step();
    chk_state("pre_clr2", 8'h80, 3'd7, 1'b0);
    mode = 3'b110;
    step();
    chk_state("clr_preempt", 8'h00, 3'd0, 1'b0);

    // reserved mode holds
    mode = 3'b011; p_in = 8'h81;
    step();
    mode = 3'b001; s_in_msb = 1'b0;
    step();
    mode = 3'b111;
    step();
    chk_state("reserved_hold", 8'h40, 3'd1, 1'b0);

    // rotate modes
    mode = 3'b011; p_in = 8'h81;
    step();
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    mode = 3'b100;
    step();
    chk_state("rotr", 8'hC0, 3'd1, 1'b0);
    mode = 3'b101;
    step();
    chk_state("rotl", 8'h81, 3'd2, 1'b0);
    mode = 3'b011;
    step();
    mode = 3'b100;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_state($sformatf("rotr%0d", k), rot_q[k], 3'((k + 1) % 8), (k == 7));
    end
`else
    mode = 3'b100; s_in_msb = 1'b1;
    step();
    chk_state("rotr_off", 8'h81, 3'd0, 1'b0);
    mode = 3'b101; s_in_lsb = 1'b1;
    step();
    chk_state("rotl_off", 8'h81, 3'd0, 1'b0);
    chk("rot_table_unused", 32'(rot_q[7]), 32'(Q));
`endif

    // async reset mid-frame
    mode = 3'b011; p_in = 8'h00;
    step();
    mode = 3'b001; s_in_msb = 1'b1;
    repeat (5) step();
    chk_state("mid_frame", 8'hF8, 3'd5, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_state("rst_mid_async", 8'hA5, 3'd0, 1'b0);
    repeat (3) begin
      step();
      chk_state("rst_mid_held", 8'hA5, 3'd0, 1'b0);
    end
    rst = 1'b0;
    step();
    chk_state("post_rst_first", 8'hD2, 3'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
